// File: rtl/ras_bob_if.sv
// ras_bob_if
//   Bundles the allocate / resolve / retire signals of the branch order
//   buffer (ras_bob) so the fetch, resolve and retire sides connect through
//   one port.
//   Parameters: IDX_W = tag width, PTR_W = RAS pointer width.
//   Modports:
//     slave  - the buffer itself (takes *_i, drives *_o)
//     master - the environment driving the buffer (drives *_i, takes *_o)
//   Signals:
//     alloc_vld_i / alloc_ras_ptr_i / alloc_rdy_o / alloc_tag_o  allocate
//     rslv_vld_i / rslv_tag_i / rslv_misp_i                      resolve
//     retire_en_i / flush_ext_i                                  retire ctrl
//     retire_vld_o / flush_rt_o / bob_vld_o / ras_ptr_rt_o       retire/restore
interface ras_bob_if #(
  parameter int IDX_W = 4,
  parameter int PTR_W = 4
);
  logic             alloc_vld_i;
  logic [PTR_W-1:0] alloc_ras_ptr_i;
  logic             alloc_rdy_o;
  logic [IDX_W-1:0] alloc_tag_o;
  logic             rslv_vld_i;
  logic [IDX_W-1:0] rslv_tag_i;
  logic             rslv_misp_i;
  logic             retire_en_i;
  logic             flush_ext_i;
  logic             retire_vld_o;
  logic             flush_rt_o;
  logic             bob_vld_o;
  logic [PTR_W-1:0] ras_ptr_rt_o;

  modport slave (
    input  alloc_vld_i, alloc_ras_ptr_i, rslv_vld_i, rslv_tag_i, rslv_misp_i,
           retire_en_i, flush_ext_i,
    output alloc_rdy_o, alloc_tag_o, retire_vld_o, flush_rt_o, bob_vld_o,
           ras_ptr_rt_o
  );

  modport master (
    output alloc_vld_i, alloc_ras_ptr_i, rslv_vld_i, rslv_tag_i, rslv_misp_i,
           retire_en_i, flush_ext_i,
    input  alloc_rdy_o, alloc_tag_o, retire_vld_o, flush_rt_o, bob_vld_o,
           ras_ptr_rt_o
  );
endinterface

// File: rtl/ras_bob.sv
// ras_bob - branch order buffer for the return-address stack
//   Checkpoints the RAS pointer of every in-flight predicted branch. Entries
//   are allocated in fetch order, marked DONE/MISP by the resolve unit and
//   retired in order from the head. A mispredicted head drives the RAS
//   restore triple (flush_rt_o, bob_vld_o, ras_ptr_rt_o) and clears the
//   buffer on the following edge; flush_ext_i clears it without a restore.
// Ports:
//   clock  - single clock
//   reset  - synchronous, active-high
//   bus    - ras_bob_if.slave (allocate, resolve, retire, restore signals)
//   perf_ret_cnt_o / perf_misp_cnt_o - 32-bit retire / misprediction
//            counters, present only when RAS_BOB_PERF_CNT_EN is defined
// Configuration macro: RAS_BOB_PERF_CNT_EN
module ras_bob #(
  parameter int DEPTH = 16,
  parameter int IDX_W = 4,
  parameter int PTR_W = 4
) (
  input  logic        clock,
  input  logic        reset,
  ras_bob_if.slave    bus
`ifdef RAS_BOB_PERF_CNT_EN
  ,
  output logic [31:0] perf_ret_cnt_o,
  output logic [31:0] perf_misp_cnt_o
`endif
);

  typedef enum logic [1:0] {
    ST_FREE = 2'd0,
    ST_PEND = 2'd1,
    ST_DONE = 2'd2,
    ST_MISP = 2'd3
  } ent_st_e;

  localparam logic [IDX_W:0] DEPTH_C = (IDX_W + 1)'(DEPTH);

  ent_st_e          st_r  [DEPTH];
  logic [PTR_W-1:0] ptr_r [DEPTH];
  logic [IDX_W-1:0] head_r;
  logic [IDX_W-1:0] tail_r;
  logic [IDX_W:0]   count_r;

  ent_st_e          head_st_s;
  logic             retire_vld_s;
  logic             flush_rt_s;
  logic             alloc_rdy_s;
  logic             alloc_fire_s;
  logic             rslv_ok_s;
  logic             clear_s;
  logic [IDX_W:0]   count_nxt_s;

  // Retire / allocate / resolve decisions from the current entry state
  always_comb begin
    head_st_s    = st_r[head_r];
    retire_vld_s = bus.retire_en_i & ~bus.flush_ext_i &
                   ((head_st_s == ST_DONE) | (head_st_s == ST_MISP));
    flush_rt_s   = retire_vld_s & (head_st_s == ST_MISP);
    clear_s      = flush_rt_s | bus.flush_ext_i;
    // Full is judged on the current count; a same-cycle retire frees nothing.
    alloc_rdy_s  = (count_r != DEPTH_C) & ~flush_rt_s & ~bus.flush_ext_i;
    alloc_fire_s = bus.alloc_vld_i & alloc_rdy_s;
    // Only a PEND entry accepts a resolve. The entry at tail is never PEND
    // when an alloc fires, so a same-tag resolve is dropped; the explicit
    // tail term keeps that ordering obvious.
    rslv_ok_s    = bus.rslv_vld_i & (st_r[bus.rslv_tag_i] == ST_PEND) &
                   ~(alloc_fire_s & (bus.rslv_tag_i == tail_r));
  end

  // Occupancy count next value: +1 alloc, -1 retire, unchanged for both
  always_comb begin
    count_nxt_s = count_r;
    case ({alloc_fire_s, retire_vld_s})
      2'b10:   count_nxt_s = count_r + (IDX_W + 1)'(1);
      2'b01:   count_nxt_s = count_r - (IDX_W + 1)'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Entry array and head/tail/count state
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        st_r[i]  <= ST_FREE;
        ptr_r[i] <= '0;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else if (clear_s) begin
      // Pointer fields are left stale; only the state marks validity.
      for (int i = 0; i < DEPTH; i++) begin
        st_r[i] <= ST_FREE;
      end
      head_r  <= '0;
      tail_r  <= '0;
      count_r <= '0;
    end else begin
      if (rslv_ok_s) begin
        st_r[bus.rslv_tag_i] <= bus.rslv_misp_i ? ST_MISP : ST_DONE;
      end
      if (retire_vld_s) begin
        st_r[head_r] <= ST_FREE;
        head_r       <= head_r + IDX_W'(1);
      end
      if (alloc_fire_s) begin
        st_r[tail_r]  <= ST_PEND;
        ptr_r[tail_r] <= bus.alloc_ras_ptr_i;
        tail_r        <= tail_r + IDX_W'(1);
      end
      count_r <= count_nxt_s;
    end
  end

  assign bus.alloc_rdy_o  = alloc_rdy_s;
  assign bus.alloc_tag_o  = tail_r;
  assign bus.retire_vld_o = retire_vld_s;
  assign bus.flush_rt_o   = flush_rt_s;
  assign bus.bob_vld_o    = (count_r != (IDX_W + 1)'(0));
  assign bus.ras_ptr_rt_o = ptr_r[head_r];

`ifdef RAS_BOB_PERF_CNT_EN
  // Retire and misprediction counters; survive flushes, cleared by reset
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_ret_cnt_o  <= 32'd0;
      perf_misp_cnt_o <= 32'd0;
    end else begin
      if (retire_vld_s) begin
        perf_ret_cnt_o <= perf_ret_cnt_o + 32'd1;
      end
      if (flush_rt_s) begin
        perf_misp_cnt_o <= perf_misp_cnt_o + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_ras_bob.sv
// tb_ras_bob - scoreboard bench for ras_bob.
//   Stimulus pushes expected retire events and expected per-cycle output
//   values into queues; a single negedge monitor pops and compares them.
module tb_ras_bob;

  localparam int S_RDY   = 0;
  localparam int S_TAG   = 1;
  localparam int S_RET   = 2;
  localparam int S_FLUSH = 3;
  localparam int S_BOB   = 4;
  localparam int S_PTR   = 5;
  localparam int S_PRET  = 6;
  localparam int S_PMISP = 7;

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic       flush;
    logic [3:0] ptr;
  } ret_t;

  logic clock;
  logic reset;
  logic done;
  int   n_cmp;
  int   n_err;

  chk_t        chk_q[$];
  ret_t        ret_q[$];
  chk_t        c_m;
  ret_t        r_m;
  logic [31:0] a_m;

`ifdef RAS_BOB_PERF_CNT_EN
  logic [31:0] perf_ret_cnt;
  logic [31:0] perf_misp_cnt;
`endif

  ras_bob_if #(.IDX_W(4), .PTR_W(4)) bif ();

  ras_bob #(.DEPTH(16), .IDX_W(4), .PTR_W(4)) dut (
    .clock           (clock),
    .reset           (reset),
    .bus             (bif.slave)
`ifdef RAS_BOB_PERF_CNT_EN
    ,
    .perf_ret_cnt_o  (perf_ret_cnt),
    .perf_misp_cnt_o (perf_misp_cnt)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] act_of(input int sel);
    case (sel)
      S_RDY:   return {31'd0, bif.alloc_rdy_o};
      S_TAG:   return {28'd0, bif.alloc_tag_o};
      S_RET:   return {31'd0, bif.retire_vld_o};
      S_FLUSH: return {31'd0, bif.flush_rt_o};
      S_BOB:   return {31'd0, bif.bob_vld_o};
      S_PTR:   return {28'd0, bif.ras_ptr_rt_o};
`ifdef RAS_BOB_PERF_CNT_EN
      S_PRET:  return perf_ret_cnt;
      S_PMISP: return perf_misp_cnt;
`endif
      default: return 32'hDEAD_BEEF;
    endcase
  endfunction

  task automatic ex(input string nm, input int sel, input logic [31:0] v);
    chk_t c;
    c.name = nm;
    c.sel  = sel;
    c.exp  = v;
    chk_q.push_back(c);
  endtask

  task automatic ex_ret(input logic fl, input logic [3:0] p);
    ret_t r;
    r.flush = fl;
    r.ptr   = p;
    ret_q.push_back(r);
  endtask

  // Advance to just after the next posedge and drive the inputs.
  task automatic cyc(input logic av, input logic [3:0] ap, input logic rv,
                     input logic [3:0] rt, input logic rm, input logic re,
                     input logic fe);
    @(posedge clock);
    #1;
    bif.alloc_vld_i     = av;
    bif.alloc_ras_ptr_i = ap;
    bif.rslv_vld_i      = rv;
    bif.rslv_tag_i      = rt;
    bif.rslv_misp_i     = rm;
    bif.retire_en_i     = re;
    bif.flush_ext_i     = fe;
  endtask

  // Monitor: retire scoreboard, per-cycle expectations, final summary
  always @(negedge clock) begin
    if (!reset) begin
      if (bif.retire_vld_o) begin
        n_cmp++;
        if (ret_q.size() == 0) begin
          n_err++;
          $display("FAIL retire_unexpected: retire_vld_o=1 flush_rt_o=%0b ptr=%0d, none required",
                   bif.flush_rt_o, bif.ras_ptr_rt_o);
        end else begin
          r_m = ret_q.pop_front();
          if (bif.flush_rt_o !== r_m.flush || bif.ras_ptr_rt_o !== r_m.ptr) begin
            n_err++;
            $display("FAIL retire_event: got flush=%0b ptr=%0d, required flush=%0b ptr=%0d",
                     bif.flush_rt_o, bif.ras_ptr_rt_o, r_m.flush, r_m.ptr);
          end
        end
      end else if (bif.flush_rt_o !== 1'b0) begin
        n_cmp++;
        n_err++;
        $display("FAIL flush_without_retire: flush_rt_o=%0b with retire_vld_o=0", bif.flush_rt_o);
      end
    end
    while (chk_q.size() > 0) begin
      c_m = chk_q.pop_front();
      a_m = act_of(c_m.sel);
      n_cmp++;
      if (a_m !== c_m.exp) begin
        n_err++;
        $display("FAIL %s: got %0h, required %0h at %0t", c_m.name, a_m, c_m.exp, $time);
      end
    end
    if (done) begin
      n_cmp++;
      if (ret_q.size() != 0) begin
        n_err++;
        $display("FAIL scoreboard_drain: %0d retire events never seen, required 0", ret_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    done  = 1'b0;
    reset = 1'b1;
    bif.alloc_vld_i     = 1'b0;
    bif.alloc_ras_ptr_i = 4'd0;
    bif.rslv_vld_i      = 1'b0;
    bif.rslv_tag_i      = 4'd0;
    bif.rslv_misp_i     = 1'b0;
    bif.retire_en_i     = 1'b0;
    bif.flush_ext_i     = 1'b0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    ex("rst_rdy", S_RDY, 32'd1);   ex("rst_tag", S_TAG, 32'd0);
    ex("rst_bob", S_BOB, 32'd0);   ex("rst_flush", S_FLUSH, 32'd0);
    ex("rst_ptr", S_PTR, 32'd0);   ex("rst_ret", S_RET, 32'd0);

    // In-order retire: head PEND blocks a resolved younger entry
    cyc(1'b1, 4'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("a0_tag", S_TAG, 32'd0); ex("a0_rdy", S_RDY, 32'd1);
    cyc(1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("a1_tag", S_TAG, 32'd1);
    cyc(1'b1, 4'd5, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("a2_tag", S_TAG, 32'd2);
    cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    ex("head_pend_ret", S_RET, 32'd0); ex("head_pend_bob", S_BOB, 32'd1); ex("head_pend_ptr", S_PTR, 32'd3);
    cyc(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0); ex("no_bypass_ret", S_RET, 32'd0);
    ex_ret(1'b0, 4'd3); ex_ret(1'b0, 4'd4);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex("ret0", S_RET, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex("ret1", S_RET, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    ex("head2_ret", S_RET, 32'd0); ex("head2_ptr", S_PTR, 32'd5);
    ex("head2_bob", S_BOB, 32'd1); ex("head2_tag", S_TAG, 32'd3);
    cyc(1'b0, 4'd0, 1'b1, 4'd2, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex_ret(1'b1, 4'd5);
    ex("misp5_flush", S_FLUSH, 32'd1); ex("misp5_bob", S_BOB, 32'd1);
    ex("misp5_ptr", S_PTR, 32'd5);     ex("misp5_rdy", S_RDY, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ex("post_misp_bob", S_BOB, 32'd0); ex("post_misp_tag", S_TAG, 32'd0); ex("post_misp_rdy", S_RDY, 32'd1);

    // Fill to DEPTH, retire with a blocked alloc, tail wrap, external flush
    for (int i = 0; i < 16; i++) begin
      cyc(1'b1, 4'(i), 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
      ex("fill_tag", S_TAG, 32'(i));
    end
    cyc(1'b1, 4'd15, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ex("full_rdy", S_RDY, 32'd0); ex("full_bob", S_BOB, 32'd1); ex("full_ptr", S_PTR, 32'd0);
    cyc(1'b1, 4'd7, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); ex("full_rslv_ret", S_RET, 32'd0);
    cyc(1'b1, 4'd7, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex_ret(1'b0, 4'd0);
    ex("full_ret_rdy", S_RDY, 32'd0); ex("full_ret_vld", S_RET, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ex("wrap_rdy", S_RDY, 32'd1); ex("wrap_tag", S_TAG, 32'd0); ex("wrap_ptr", S_PTR, 32'd1);
    cyc(1'b1, 4'd12, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("wrap_alloc_tag", S_TAG, 32'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0); ex("refull_rdy", S_RDY, 32'd0);
    cyc(1'b1, 4'd3, 1'b1, 4'd2, 1'b0, 1'b1, 1'b1);
    ex("fext_ret", S_RET, 32'd0); ex("fext_flush", S_FLUSH, 32'd0);
    ex("fext_rdy", S_RDY, 32'd0); ex("fext_bob", S_BOB, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ex("post_fext_bob", S_BOB, 32'd0); ex("post_fext_tag", S_TAG, 32'd0); ex("post_fext_rdy", S_RDY, 32'd1);

    // Mispredicted head with checkpoint 9
    cyc(1'b1, 4'd9, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("m9_tag", S_TAG, 32'd0);
    cyc(1'b1, 4'd2, 1'b1, 4'd0, 1'b1, 1'b0, 1'b0); ex("m9_tag1", S_TAG, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex_ret(1'b1, 4'd9);
    ex("m9_flush", S_FLUSH, 32'd1); ex("m9_bob", S_BOB, 32'd1);
    ex("m9_ptr", S_PTR, 32'd9);     ex("m9_ret", S_RET, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    ex("post_m9_bob", S_BOB, 32'd0); ex("post_m9_tag", S_TAG, 32'd0);

    // Same-tag alloc+resolve drops the resolve; resolve of a FREE entry is ignored
    cyc(1'b1, 4'd1, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0); ex("same_tag_tag", S_TAG, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex("same_tag_ret", S_RET, 32'd0);
    cyc(1'b0, 4'd0, 1'b1, 4'd0, 1'b0, 1'b1, 1'b0); ex("rslv_again_ret", S_RET, 32'd0);
    ex_ret(1'b0, 4'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex("same_tag_retire", S_RET, 32'd1);
    cyc(1'b0, 4'd0, 1'b1, 4'd1, 1'b1, 1'b0, 1'b0); ex("free_rslv_bob", S_BOB, 32'd0);
    cyc(1'b1, 4'd8, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("free_rslv_tag", S_TAG, 32'd1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
    ex("free_rslv_ret", S_RET, 32'd0); ex("free_rslv_ptr", S_PTR, 32'd8); ex("free_rslv_bobv", S_BOB, 32'd1);
`ifdef RAS_BOB_PERF_CNT_EN
    ex("perf_ret", S_PRET, 32'd6); ex("perf_misp", S_PMISP, 32'd2);
`endif
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); ex("clr_bob", S_BOB, 32'd0);
`ifdef RAS_BOB_PERF_CNT_EN
    ex("perf_ret_keep", S_PRET, 32'd6); ex("perf_misp_keep", S_PMISP, 32'd2);
`endif

    // Reset mid-operation overrides concurrent alloc/resolve
    cyc(1'b1, 4'd4, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd6, 1'b1, 4'd0, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 4'd9, 1'b1, 4'd1, 1'b0, 1'b0, 1'b0); reset = 1'b1;
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0); reset = 1'b0;
    ex("mrst_tag", S_TAG, 32'd0); ex("mrst_bob", S_BOB, 32'd0);
    ex("mrst_ptr", S_PTR, 32'd0); ex("mrst_rdy", S_RDY, 32'd1);
`ifdef RAS_BOB_PERF_CNT_EN
    ex("perf_ret_rst", S_PRET, 32'd0); ex("perf_misp_rst", S_PMISP, 32'd0);
`endif
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0); ex("mrst_ret", S_RET, 32'd0);
    cyc(1'b0, 4'd0, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
    done = 1'b1;
  end

endmodule
